// File: rtl/stream_demux_if.sv
// stream_demux_if: input stream plus two output streams of the 1-to-2 stream demultiplexer.
interface stream_demux_if #(parameter int Width = 16);
  logic [Width-1:0] s_data;
  logic             s_sel;
  logic             s_valid;
  logic             s_ready;
  logic [Width-1:0] m0_data;
  logic             m0_valid;
  logic             m0_ready;
  logic [Width-1:0] m1_data;
  logic             m1_valid;
  logic             m1_ready;
  modport master (
    output s_data, s_sel, s_valid, m0_ready, m1_ready,
    input  s_ready, m0_data, m0_valid, m1_data, m1_valid
  );
  modport slave (
    input  s_data, s_sel, s_valid, m0_ready, m1_ready,
    output s_ready, m0_data, m0_valid, m1_data, m1_valid
  );
endinterface

// File: rtl/stream_demux.sv
// stream_demux: 1-to-2 valid/ready demux with a 2-entry elastic buffer per output.
// Defining STREAM_DEMUX_STATS_EN adds saturating per-output transfer counters.
module stream_demux #(
  parameter int Width = 16
) (
  input logic           clk_i,
  input logic           rst_ni,
  stream_demux_if.slave bus
`ifdef STREAM_DEMUX_STATS_EN
  ,
  output logic [15:0]   m0_count_o,
  output logic [15:0]   m1_count_o
`endif
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} occ_t;
  logic [1:0]            push, pop, valid, full;
  logic [1:0][Width-1:0] data;
  // Ready looks only at the selected channel's occupancy, never at consumer readies.
  assign bus.s_ready  = ~full[bus.s_sel];
  assign push         = {bus.s_sel, ~bus.s_sel} & {2{bus.s_valid & bus.s_ready}};
  assign pop          = valid & {bus.m1_ready, bus.m0_ready};
  assign bus.m0_valid = valid[0];
  assign bus.m1_valid = valid[1];
  assign bus.m0_data  = data[0];
  assign bus.m1_data  = data[1];
`ifdef STREAM_DEMUX_STATS_EN
  logic [1:0][15:0] count;
  assign m0_count_o = count[0];
  assign m1_count_o = count[1];
`endif
  for (genvar k = 0; k < 2; k++) begin : g_ch
    occ_t             state, state_nxt;
    logic [Width-1:0] head, tail, head_nxt, tail_nxt;
    logic             v, f;
    always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
        state <= EMPTY;
        head  <= '0;
        tail  <= '0;
      end else begin
        state <= state_nxt;
        head  <= head_nxt;
        tail  <= tail_nxt;
      end
    // Head is zeroed on the last pop so the output reads zero whenever empty.
    always_comb begin
      state_nxt = state;
      head_nxt  = head;
      tail_nxt  = tail;
      case (state)
        EMPTY: if (push[k]) begin
          state_nxt = ONE;
          head_nxt  = bus.s_data;
        end
        ONE: if (push[k] && pop[k]) head_nxt = bus.s_data;
        else if (push[k]) begin
          state_nxt = FULL;
          tail_nxt  = bus.s_data;
        end else if (pop[k]) begin
          state_nxt = EMPTY;
          head_nxt  = '0;
        end
        FULL: if (pop[k]) begin
          state_nxt = ONE;
          head_nxt  = tail;
        end
        default: state_nxt = EMPTY;
      endcase
    end
    always_comb begin
      v = state != EMPTY;
      f = state == FULL;
    end
    assign valid[k] = v;
    assign full[k]  = f;
    assign data[k]  = head;
`ifdef STREAM_DEMUX_STATS_EN
    logic [15:0] cnt;
    always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) cnt <= '0;
      else if (pop[k] && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
    assign count[k] = cnt;
`endif
  end
endmodule
